// File: rtl/bpfvm_forwarder.sv
// Packet egress from bpfvm memory: 64-bit reads streamed as a byte stream with keep/last.
// Optional BPFVM_FORWARDER_STATS_EN adds packet and byte counters.
module bpfvm_forwarder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LEN_WIDTH  = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ready_for_forwarder,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  output logic [ADDR_WIDTH-1:0] forwarder_rd_addr,
  output logic                  forwarder_rd_en,
  input  logic [63:0]           forwarder_rd_data,
  output logic                  forwarder_done,
  output logic [63:0]           m_tdata,
  output logic [7:0]            m_tkeep,
  output logic                  m_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready
`ifdef BPFVM_FORWARDER_STATS_EN
  , output logic [31:0]         pkt_count
  , output logic [31:0]         byte_count
`endif
);

  localparam int unsigned BeatW = ADDR_WIDTH;
  localparam logic [LEN_WIDTH:0] MaxLen = {{LEN_WIDTH{1'b0}}, 1'b1} << (ADDR_WIDTH + 2);

  typedef enum logic [1:0] {StIdle, StStream, StDone, StRelease} state_e;

  state_e           state_q, state_d;
  logic [2:0]       rem_q, rem_d;
  logic [BeatW-1:0] beats_q, beats_d;
  logic [BeatW-1:0] issued_q, issued_d;

  logic             inflight_q;
  logic [7:0]       inf_keep_q;
  logic             inf_last_q;

  logic [63:0]      fifo_data_q [2];
  logic [7:0]       fifo_keep_q [2];
  logic             fifo_last_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       cnt_q;

  logic [LEN_WIDTH:0] len_c;
  logic             fifo_empty, pop, push_fifo, pop_fifo, issue_ok, issue_last;
  logic [7:0]       issue_keep;
  logic [2:0]       occ;
  logic [63:0]      head_data;
  logic [7:0]       head_keep;
  logic             head_last;

  assign len_c = ({1'b0, pkt_len} > MaxLen) ? MaxLen : {1'b0, pkt_len};

  // The read in flight is treated as the FIFO tail so its data can bypass to the output.
  assign fifo_empty = (cnt_q == 2'd0);
  assign m_tvalid   = !fifo_empty || inflight_q;
  assign pop        = m_tvalid && m_tready;
  assign push_fifo  = inflight_q && !(fifo_empty && pop);
  assign pop_fifo   = pop && !fifo_empty;
  assign occ        = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

  assign head_data = fifo_empty ? forwarder_rd_data : fifo_data_q[rd_ptr_q];
  assign head_keep = fifo_empty ? inf_keep_q : fifo_keep_q[rd_ptr_q];
  assign head_last = fifo_empty ? inf_last_q : fifo_last_q[rd_ptr_q];

  assign m_tdata = m_tvalid ? head_data : 64'd0;
  assign m_tkeep = m_tvalid ? head_keep : 8'd0;
  assign m_tlast = m_tvalid && head_last;

  assign issue_ok   = (state_q == StStream) && (issued_q < beats_q) && (occ < 3'd2);
  assign issue_last = (issued_q == beats_q - 1'b1);
  assign issue_keep = (issue_last && rem_q != 3'd0) ? (8'hFF << (4'd8 - {1'b0, rem_q})) : 8'hFF;

  assign forwarder_rd_en   = issue_ok;
  assign forwarder_rd_addr = {issued_q[ADDR_WIDTH-2:0], 1'b0};
  assign forwarder_done    = (state_q == StDone);

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    beats_d  = beats_q;
    issued_d = issue_ok ? issued_q + 1'b1 : issued_q;
    unique case (state_q)
      StIdle: begin
        if (ready_for_forwarder) begin
          rem_d    = len_c[2:0];
          beats_d  = BeatW'((len_c + (LEN_WIDTH + 1)'(7)) >> 3);
          issued_d = '0;
          state_d  = (beats_d == '0) ? StDone : StStream;
        end
      end
      StStream:  if (pop && head_last) state_d = StDone;
      StDone:    state_d = StRelease;
      StRelease: if (!ready_for_forwarder) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      rem_q      <= '0;
      beats_q    <= '0;
      issued_q   <= '0;
      inflight_q <= 1'b0;
      inf_keep_q <= '0;
      inf_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      beats_q    <= beats_d;
      issued_q   <= issued_d;
      inflight_q <= issue_ok;
      inf_keep_q <= issue_keep;
      inf_last_q <= issue_last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_keep_q[i] <= '0;
        fifo_last_q[i] <= 1'b0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (push_fifo) begin
        fifo_data_q[wr_ptr_q] <= forwarder_rd_data;
        fifo_keep_q[wr_ptr_q] <= inf_keep_q;
        fifo_last_q[wr_ptr_q] <= inf_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop_fifo) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, push_fifo} - {1'b0, pop_fifo};
    end
  end

`ifdef BPFVM_FORWARDER_STATS_EN
  logic [LEN_WIDTH:0] len_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q      <= '0;
      pkt_count  <= '0;
      byte_count <= '0;
    end else begin
      if (state_q == StIdle && ready_for_forwarder) len_q <= len_c;
      if (state_q == StDone) begin
        pkt_count  <= pkt_count + 32'd1;
        byte_count <= byte_count + 32'(len_q);
      end
    end
  end
`endif

endmodule

// File: tb/tb_bpfvm_forwarder.sv
// Directed bench for bpfvm_forwarder: memory model, stream monitor and per-scenario checks.
module tb_bpfvm_forwarder;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready_for_forwarder;
  logic [12:0] pkt_len;
  logic [9:0]  forwarder_rd_addr;
  logic        forwarder_rd_en;
  logic [63:0] forwarder_rd_data;
  logic        forwarder_done;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tlast, m_tvalid, m_tready;
`ifdef BPFVM_FORWARDER_STATS_EN
  logic [31:0] pkt_count, byte_count;
`endif

  always #5 clk = ~clk;

  bpfvm_forwarder #(.ADDR_WIDTH(10), .LEN_WIDTH(13)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .ready_for_forwarder (ready_for_forwarder),
    .pkt_len             (pkt_len),
    .forwarder_rd_addr   (forwarder_rd_addr),
    .forwarder_rd_en     (forwarder_rd_en),
    .forwarder_rd_data   (forwarder_rd_data),
    .forwarder_done      (forwarder_done),
    .m_tdata             (m_tdata),
    .m_tkeep             (m_tkeep),
    .m_tlast             (m_tlast),
    .m_tvalid            (m_tvalid),
    .m_tready            (m_tready)
`ifdef BPFVM_FORWARDER_STATS_EN
    , .pkt_count         (pkt_count)
    , .byte_count        (byte_count)
`endif
  );

  logic [31:0] mem [1024];
  logic [31:0] pkt_words [14];

  always @(posedge clk)
    if (forwarder_rd_en) forwarder_rd_data <= {mem[forwarder_rd_addr], mem[forwarder_rd_addr + 1]};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  logic [63:0] beat_data [$];
  logic [7:0]  beat_keep [$];
  logic        beat_last [$];
  int          beat_cyc  [$];
  int          addr_q    [$];
  int          done_cyc  [$];
  int first_rd_cyc, first_valid_cyc, viol_out, viol_stable, n_issued, n_acc;
  logic        stalled;
  logic [63:0] st_data;
  logic [7:0]  st_keep;
  logic        st_last;

  task automatic clear_mon();
    beat_data.delete(); beat_keep.delete(); beat_last.delete(); beat_cyc.delete();
    addr_q.delete(); done_cyc.delete();
    first_rd_cyc = -1; first_valid_cyc = -1;
    viol_out = 0; viol_stable = 0; n_issued = 0; n_acc = 0; stalled = 1'b0;
  endtask

  // Sample everything on the falling edge, away from DUT state updates.
  initial begin
    clear_mon();
    forever begin
      @(negedge clk);
      if (forwarder_rd_en) begin
        addr_q.push_back(int'(forwarder_rd_addr));
        n_issued++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
      end
      if (m_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (stalled && rst && (!m_tvalid || m_tdata !== st_data || m_tkeep !== st_keep ||
                             m_tlast !== st_last)) viol_stable++;
      if (m_tvalid && m_tready) begin
        beat_data.push_back(m_tdata); beat_keep.push_back(m_tkeep);
        beat_last.push_back(m_tlast); beat_cyc.push_back(cyc);
        n_acc++;
      end
      if (forwarder_done) done_cyc.push_back(cyc);
      if (n_issued - n_acc > 2) viol_out++;
      stalled = rst && m_tvalid && !m_tready;
      st_data = m_tdata; st_keep = m_tkeep; st_last = m_tlast;
    end
  end

  // Raise ready with pkt_len, run until the done pulse (bounded), then drop ready.
  task automatic send(input string name, input int len, input bit rnd, output int e0);
    clear_mon();
    @(posedge clk); #1;
    pkt_len = 13'(len);
    ready_for_forwarder = 1'b1;
    e0 = cyc;
    for (int t = 0; t < 3000 && done_cyc.size() == 0; t++) begin
      @(posedge clk); #1;
      if (rnd) m_tready = 1'($urandom_range(0, 1));
    end
    n_cmp++;
    if (done_cyc.size() == 0) begin
      n_fail++;
      $display("FAIL %s done_timeout: got no done pulse, required one", name);
    end
    ready_for_forwarder = 1'b0;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_cmp += 7;
    if (forwarder_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", forwarder_rd_en); end
    if (forwarder_rd_addr !== 10'd0) begin n_fail++; $display("FAIL reset_rd_addr: got %0d want 0", forwarder_rd_addr); end
    if (forwarder_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", forwarder_done); end
    if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
    if (m_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b want 0", m_tlast); end
    if (m_tkeep !== 8'h00) begin n_fail++; $display("FAIL reset_tkeep: got %h want 00", m_tkeep); end
    if (m_tdata !== 64'd0) begin n_fail++; $display("FAIL reset_tdata: got %h want 0", m_tdata); end
  endtask

  task automatic test_basic();
    int e0;
    send("basic", 56, 1'b0, e0);
    n_cmp += 6;
    if (first_rd_cyc != e0 + 1) begin n_fail++; $display("FAIL basic_rd_latency: got %0d want %0d", first_rd_cyc, e0 + 1); end
    if (first_valid_cyc != e0 + 2) begin n_fail++; $display("FAIL basic_valid_latency: got %0d want %0d", first_valid_cyc, e0 + 2); end
    if (beat_data.size() != 7) begin n_fail++; $display("FAIL basic_beats: got %0d want 7", beat_data.size()); end
    if (addr_q.size() != 7) begin n_fail++; $display("FAIL basic_reads: got %0d want 7", addr_q.size()); end
    if (done_cyc.size() != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", done_cyc.size()); end
    if (beat_data.size() > 0 && beat_data[0] !== 64'h70b31760a09f782b) begin
      n_fail++; $display("FAIL basic_beat0: got %h want 70b31760a09f782b", beat_data[0]);
    end
    for (int i = 0; i < 7 && i < beat_data.size() && i < addr_q.size(); i++) begin
      n_cmp += 5;
      if (beat_data[i] !== {mem[2*i], mem[2*i+1]}) begin n_fail++; $display("FAIL basic_data[%0d]: got %h want %h", i, beat_data[i], {mem[2*i], mem[2*i+1]}); end
      if (beat_keep[i] !== 8'hFF) begin n_fail++; $display("FAIL basic_keep[%0d]: got %h want ff", i, beat_keep[i]); end
      if (beat_last[i] !== (i == 6)) begin n_fail++; $display("FAIL basic_last[%0d]: got %b want %b", i, beat_last[i], i == 6); end
      if (addr_q[i] != 2 * i) begin n_fail++; $display("FAIL basic_addr[%0d]: got %0d want %0d", i, addr_q[i], 2 * i); end
      if (beat_cyc[i] != e0 + 2 + i) begin n_fail++; $display("FAIL basic_rate[%0d]: got cycle %0d want %0d", i, beat_cyc[i], e0 + 2 + i); end
    end
    if (done_cyc.size() == 1 && beat_cyc.size() == 7) begin
      n_cmp++;
      if (done_cyc[0] != beat_cyc[6] + 1) begin n_fail++; $display("FAIL basic_done_time: got %0d want %0d", done_cyc[0], beat_cyc[6] + 1); end
    end
  endtask

  task automatic test_len53();
    int e0;
    send("len53", 53, 1'b0, e0);
    n_cmp += 2;
    if (beat_data.size() != 7) begin n_fail++; $display("FAIL len53_beats: got %0d want 7", beat_data.size()); end
    if (done_cyc.size() != 1) begin n_fail++; $display("FAIL len53_done_count: got %0d want 1", done_cyc.size()); end
    if (beat_data.size() == 7) begin
      n_cmp += 4;
      if (beat_keep[6] !== 8'hF8) begin n_fail++; $display("FAIL len53_last_keep: got %h want f8", beat_keep[6]); end
      if (beat_keep[5] !== 8'hFF) begin n_fail++; $display("FAIL len53_keep5: got %h want ff", beat_keep[5]); end
      if (beat_last[6] !== 1'b1 || beat_last[5] !== 1'b0) begin n_fail++; $display("FAIL len53_last: got %b%b want 01", beat_last[5], beat_last[6]); end
      if (beat_data[6] !== {mem[12], mem[13]}) begin n_fail++; $display("FAIL len53_data6: got %h want %h", beat_data[6], {mem[12], mem[13]}); end
    end
  endtask

  task automatic test_stats();
`ifdef BPFVM_FORWARDER_STATS_EN
    n_cmp += 2;
    if (pkt_count !== 32'd2) begin n_fail++; $display("FAIL stats_pkt_count: got %0d want 2", pkt_count); end
    if (byte_count !== 32'd109) begin n_fail++; $display("FAIL stats_byte_count: got %0d want 109", byte_count); end
`endif
  endtask

  task automatic test_backpressure();
    int e0;
    send("bp", 56, 1'b1, e0);
    n_cmp += 5;
    if (beat_data.size() != 7) begin n_fail++; $display("FAIL bp_beats: got %0d want 7", beat_data.size()); end
    if (addr_q.size() != 7) begin n_fail++; $display("FAIL bp_reads: got %0d want 7", addr_q.size()); end
    if (viol_out != 0) begin n_fail++; $display("FAIL bp_outstanding: got %0d overruns want 0", viol_out); end
    if (viol_stable != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes while stalled want 0", viol_stable); end
    if (done_cyc.size() != 1) begin n_fail++; $display("FAIL bp_done_count: got %0d want 1", done_cyc.size()); end
    for (int i = 0; i < 7 && i < beat_data.size() && i < addr_q.size(); i++) begin
      n_cmp += 3;
      if (beat_data[i] !== {mem[2*i], mem[2*i+1]}) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", i, beat_data[i], {mem[2*i], mem[2*i+1]}); end
      if (beat_last[i] !== (i == 6)) begin n_fail++; $display("FAIL bp_last[%0d]: got %b want %b", i, beat_last[i], i == 6); end
      if (addr_q[i] != 2 * i) begin n_fail++; $display("FAIL bp_addr[%0d]: got %0d want %0d", i, addr_q[i], 2 * i); end
    end
  endtask

  task automatic test_zero_len();
    int e0;
    clear_mon();
    @(posedge clk); #1;
    pkt_len = 13'd0;
    ready_for_forwarder = 1'b1;
    e0 = cyc;
    repeat (8) @(posedge clk);
    #1;
    n_cmp += 4;
    if (done_cyc.size() != 1) begin n_fail++; $display("FAIL zero_done_count: got %0d want 1", done_cyc.size()); end
    if (done_cyc.size() > 0 && done_cyc[0] != e0 + 1) begin n_fail++; $display("FAIL zero_done_time: got %0d want %0d", done_cyc[0], e0 + 1); end
    if (first_valid_cyc != -1) begin n_fail++; $display("FAIL zero_tvalid: got valid at %0d want never", first_valid_cyc); end
    if (first_rd_cyc != -1) begin n_fail++; $display("FAIL zero_rd_en: got read at %0d want never", first_rd_cyc); end
    ready_for_forwarder = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int t;
    clear_mon();
    @(posedge clk); #1;
    pkt_len = 13'd56;
    m_tready = 1'b1;
    ready_for_forwarder = 1'b1;
    for (t = 0; t < 50 && n_acc < 3; t++) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if (n_acc < 3) begin n_fail++; $display("FAIL rstmid_progress: got %0d beats want >= 3", n_acc); end
    #2 rst = 1'b0;
    #1;
    test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (done_cyc.size() != 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_cyc.size()); end
    clear_mon();
    #2 rst = 1'b1;
    for (t = 0; t < 100 && done_cyc.size() == 0; t++) begin
      @(posedge clk); #1;
    end
    n_cmp += 3;
    if (beat_data.size() != 7) begin n_fail++; $display("FAIL rstmid_beats: got %0d want 7", beat_data.size()); end
    if (addr_q.size() == 0 || addr_q[0] != 0) begin n_fail++; $display("FAIL rstmid_restart_addr: got %0d reads want first at 0", addr_q.size()); end
    if (done_cyc.size() != 1) begin n_fail++; $display("FAIL rstmid_done_count: got %0d want 1", done_cyc.size()); end
    for (int i = 0; i < 7 && i < beat_data.size(); i++) begin
      n_cmp++;
      if (beat_data[i] !== {mem[2*i], mem[2*i+1]}) begin n_fail++; $display("FAIL rstmid_data[%0d]: got %h want %h", i, beat_data[i], {mem[2*i], mem[2*i+1]}); end
    end
    ready_for_forwarder = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_clamp();
    int e0;
    send("clamp", 5000, 1'b0, e0);
    n_cmp += 2;
    if (beat_data.size() != 512) begin n_fail++; $display("FAIL clamp_beats: got %0d want 512", beat_data.size()); end
    if (addr_q.size() != 512) begin n_fail++; $display("FAIL clamp_reads: got %0d want 512", addr_q.size()); end
    if (beat_data.size() == 512 && addr_q.size() == 512) begin
      n_cmp += 4;
      if (beat_keep[511] !== 8'hFF) begin n_fail++; $display("FAIL clamp_last_keep: got %h want ff", beat_keep[511]); end
      if (beat_last[511] !== 1'b1) begin n_fail++; $display("FAIL clamp_last: got %b want 1", beat_last[511]); end
      if (addr_q[511] != 1022) begin n_fail++; $display("FAIL clamp_last_addr: got %0d want 1022", addr_q[511]); end
      if (beat_data[511] !== {mem[1022], mem[1023]}) begin n_fail++; $display("FAIL clamp_last_data: got %h want %h", beat_data[511], {mem[1022], mem[1023]}); end
    end
  endtask

  initial begin
    pkt_words = '{32'h70b31760, 32'ha09f782b, 32'h1c4e9d02, 32'h5b6a7f31, 32'h8d2c4e10,
                  32'h3f9a0b77, 32'hc1d2e3f4, 32'h05a6b7c8, 32'h9e8f7a6b, 32'h2468ace0,
                  32'h13579bdf, 32'hfedcba98, 32'h0badf00d, 32'h0000ffff};
    for (int i = 0; i < 1024; i++) mem[i] = (i < 14) ? pkt_words[i] : 32'(i) * 32'h9e3779b9;
    rst = 1'b0;
    ready_for_forwarder = 1'b0;
    pkt_len = '0;
    m_tready = 1'b1;
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_basic();
    test_len53();
    test_stats();
    test_backpressure();
    test_zero_len();
    test_reset_mid();
    test_clamp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bpfvm_forwarder.md
# bpfvm_forwarder

Packet-egress engine at the read end of the bpfvm packet memory. Once the VM has accepted a packet and raises `ready_for_forwarder`, this block reads the stored packet 64 bits at a time through the forwarder read port. It streams the packet out on a valid/ready byte stream with keep and last qualifiers, then returns the buffer to the VM with a one-cycle `forwarder_done` pulse. It is the consumer counterpart of the snooper, which writes packets into the same memory.

## Interface
- `ADDR_WIDTH`, 10: width of `forwarder_rd_addr`; the address counts 32-bit words.
- `LEN_WIDTH`, 13: width of `pkt_len`, in bytes; maximum byte count is 2^(ADDR_WIDTH+2).
- `clk`  in  1  single clock domain for the whole block.
- `rst`  in  1  asynchronous, active-low reset.
- `ready_for_forwarder`  in  1  the VM holds an accepted packet.
- `pkt_len`  in  LEN_WIDTH  packet byte length; valid while `ready_for_forwarder` is high.
- `forwarder_rd_addr`  out  ADDR_WIDTH  32-bit word address; always even.
- `forwarder_rd_en`  out  1  read strobe.
- `forwarder_rd_data`  in  64  read data, one cycle after `forwarder_rd_en`.
- `forwarder_done`  out  1  one-cycle release pulse.
- `m_tdata`  out  64  byte 0 of each beat is in [63:56].
- `m_tkeep`  out  8  bit i qualifies byte lane [8i+7:8i].
- `m_tlast`, `m_tvalid`  out  1  beat qualifiers.
- `m_tready`  in  1  downstream accept.

## Operation
- States:
  - IDLE
    - Sample `ready_for_forwarder`.
    - When it is high: latch len = min(`pkt_len`, 2^(ADDR_WIDTH+2)) and beats = ceil(len/8).
    - Clear the read-issue and beat counters.
    - Go to STREAM, or to DONE if beats = 0.
  - STREAM
    - Issue reads at word addresses 0, 2, 4, … (2·issued).
    - Go to DONE on the handshake (`m_tvalid`&`m_tready`) of beat number beats.
  - DONE
    - `forwarder_done`=1 for exactly this cycle; then go to RELEASE.
  - RELEASE
    - Wait for `ready_for_forwarder`=0, then go to IDLE.
    - This prevents a re-trigger on the old packet.
- Buffering:
  - 2-entry output FIFO.
  - A read issues only when issued < beats and (FIFO count + in-flight reads − pop this cycle) < 2.
  - Hence at most 2 beats are outstanding, no beat is ever dropped, and no read is ever repeated.
- Each FIFO entry carries data, keep and last.
  - keep = 8'hFF except on the final beat, where the top (len mod 8) bits are set (8'hFF if the remainder is 0).
  - last = 1 only on beat number beats.
- `m_tvalid` = FIFO non-empty. Output data is held stable while `m_tvalid`&&!`m_tready`.
- A `ready_for_forwarder` drop during STREAM is ignored; the packet completes.
- A length clamp applies to `pkt_len` > 4096 (default parameters): exactly 512 beats are sent.

## Timing
- Reset (async assert, sync release): state IDLE, FIFO empty, counters 0.
  - All outputs read 0: `forwarder_rd_en`, `forwarder_rd_addr`, `forwarder_done`, `m_tvalid`, `m_tlast`, `m_tkeep`, `m_tdata`.
- Reset mid-packet: the partial stream is abandoned and no done pulse is issued. After reset, a still-high `ready_for_forwarder` restarts the packet from address 0.
- Latency (ready seen high at IDLE edge k):
  - `forwarder_rd_en` is high in cycle k+1.
  - First `m_tvalid` is in cycle k+2.
- Throughput: 1 beat per cycle while `m_tready`=1.
- Done timing: last-beat handshake at edge t → `forwarder_done` high in cycle t+1 only. For len = 0, done is high in cycle k+1.
- Simultaneous FIFO push and pop with FIFO count 2 cannot occur; the issue rule prevents it.

## Configuration
- `BPFVM_FORWARDER_STATS_EN` defined:
  - Adds outputs `pkt_count` (32) and `byte_count` (32), both reset to 0.
  - In the DONE cycle, `pkt_count` += 1 and `byte_count` += latched len.
  - Both counters wrap modulo 2^32.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

## Test plan
- Accepted 56-byte packet (words 70b31760, a09f782b, …, 0000FFFF), `m_tready`=1:
  - 7 beats; beat 0 = 64'h70b31760a09f782b.
  - Keep 8'hFF on every beat; `m_tlast` on beat 7 only.
  - Read addresses 0,2,…,12; done one cycle after beat 7.
- `pkt_len`=53:
  - 7 beats; last-beat keep 8'hF8; done pulse exactly one cycle.
- `m_tready` pseudo-random at 50%:
  - Beat sequence identical to the first scenario; no duplicate or missing addresses.
  - Never more than 2 reads ahead of accepted beats; data stable while stalled.
- `pkt_len`=0:
  - `m_tvalid` never rises; `forwarder_done` high in cycle k+1.
  - Stays in RELEASE until ready falls, with no second pulse.
- `rst`=0 after beat 3 with ready still high:
  - All outputs 0; no done pulse.
  - After release the packet restarts at address 0 and all 7 beats are delivered.
- With `BPFVM_FORWARDER_STATS_EN`, send packets of 56 then 53 bytes:
  - `pkt_count`=2, `byte_count`=109.
